// File: rtl/sdram_burst_reader_if.sv
// Avalon-MM burst read bus plus the output stream of sdram_burst_reader.
// master: the reader side; slave: the SDRAM port and stream consumer side.
interface sdram_burst_reader_if #(
  parameter int unsigned ADDR_W  = 29,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BURST_W = 8
);
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               read;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output address, burstcount, read,
    input  waitrequest, readdata, readdatavalid,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  address, burstcount, read,
    output waitrequest, readdata, readdatavalid,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/sdram_burst_reader.sv
// Credit-based Avalon-MM burst read master feeding a show-ahead FIFO and valid/ready stream.
// Optional XOR checksum of all pushed words when SDRAM_RD_CHECKSUM_EN is defined.
module sdram_burst_reader #(
  parameter int unsigned ADDR_W     = 29,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned BURST_W    = 8,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned LEN_W      = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    num_words,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum,
  sdram_burst_reader_if.master bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               zero_done_q, zero_done_d;

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   len_cnt;
  logic [SUM_W-1:0]   credit_sum;
  logic               issue_ok, accept, push, pop;

  assign len        = (remaining_q < LEN_W'(MAX_BURST)) ? remaining_q : LEN_W'(MAX_BURST);
  assign len_cnt    = CNT_W'(len);
  // Words buffered plus words promised must leave room for the whole next burst.
  assign credit_sum = SUM_W'(count_q) + SUM_W'(outstanding_q) + SUM_W'(len_cnt);
  assign issue_ok   = (state_q == StIssue) && (credit_sum <= SUM_W'(FIFO_DEPTH));
  assign accept     = issue_ok && !bus.waitrequest;
  // Beats with nothing outstanding are stale (e.g. after reset) and dropped.
  assign push       = bus.readdatavalid && (outstanding_q != '0);
  assign pop        = bus.out_valid && bus.out_ready;

  assign bus.read       = issue_ok;
  assign bus.address    = issue_ok ? cur_addr_q : '0;
  assign bus.burstcount = issue_ok ? BURST_W'(len) : '0;
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = mem_q[rd_ptr_q];

  assign busy = (state_q != StIdle);
  assign done = zero_done_q || ((state_q == StDrain) && (outstanding_q == '0));

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    zero_done_d   = 1'b0;
    outstanding_d = outstanding_q;
    if (accept) outstanding_d = outstanding_d + len_cnt;
    if (push)   outstanding_d = outstanding_d - CNT_W'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words != '0) begin
            cur_addr_d  = base_addr;
            remaining_d = num_words;
            state_d     = StIssue;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (accept) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(len);
          remaining_d = remaining_q - len;
          if (remaining_q == len) state_d = StDrain;
        end
      end
      StDrain: begin
        if (outstanding_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      zero_done_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      zero_done_q   <= zero_done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.readdata;
  end

`ifdef SDRAM_RD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      checksum_q <= '0;
    end else if (push) begin
      checksum_q <= checksum_q ^ bus.readdata;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_sdram_burst_reader.sv
// Randomised bench for sdram_burst_reader against a queue-based job/memory reference model.
module tb_sdram_burst_reader;
  localparam int unsigned ADDR_W     = 29;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned BURST_W    = 8;
  localparam int unsigned MAX_BURST  = 16;
  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned LEN_W      = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_words;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  sdram_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

  sdram_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
    .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .checksum(checksum), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [ADDR_W-1:0] eb_addr[$];
  int                eb_len[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [ADDR_W-1:0] pending[$];
  int                m_fifo, m_out;
  bit                job_active, zero_pend;
  logic [DATA_W-1:0] m_chk;
  int                acc_cnt, stall_cnt, read_cnt, done_cnt;
  bit                prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [BURST_W-1:0] prev_bc;

  // Stimulus knobs
  int                ready_mode, wr_hold;
  bit                wr_rand, rsp_en, rsp_rand, noise_start, mem_mode;
  logic [ADDR_W-1:0] mem_base;
  bit                start_req;
  logic [ADDR_W-1:0] req_base;
  logic [LEN_W-1:0]  req_n;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (mem_mode) return DATA_W'(a - mem_base) + 64'd1;
    return {3'b101, a, ~{3'b000, a}};
  endfunction

  task automatic accept_job(input logic [ADDR_W-1:0] base, input int n);
    logic [ADDR_W-1:0] a;
    int r, l;
    m_chk   = '0;
    acc_cnt = 0;
    if (n == 0) begin
      zero_pend = 1'b1;
    end else begin
      job_active = 1'b1;
      a = base;
      r = n;
      while (r > 0) begin
        l = (r > int'(MAX_BURST)) ? int'(MAX_BURST) : r;
        eb_addr.push_back(a);
        eb_len.push_back(l);
        a = a + ADDR_W'(l);
        r = r - l;
      end
      for (int i = 0; i < n; i++) exp_data.push_back(mem_word(base + ADDR_W'(i)));
    end
  endtask

  task automatic step();
    bit acc, rdv, pop, exp_done, idle0;
    int m_out0, l;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    start = 1'b0;
    if (start_req) begin
      start     = 1'b1;
      base_addr = req_base;
      num_words = req_n;
      start_req = 1'b0;
    end else if (noise_start && job_active && ($urandom_range(0, 15) == 0)) begin
      start     = 1'b1;
      base_addr = ADDR_W'($urandom);
      num_words = LEN_W'($urandom_range(0, 50));
    end
    if (bus.read && wr_hold > 0) begin
      bus.waitrequest = 1'b1;
      wr_hold--;
    end else begin
      bus.waitrequest = wr_rand && ($urandom_range(0, 3) == 0);
    end
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 1) != 0);
    endcase
    rdv = 1'b0;
    bus.readdata = {$urandom, $urandom};
    if (rsp_en && pending.size() > 0 && (!rsp_rand || $urandom_range(0, 2) != 0)) begin
      rdv = 1'b1;
      bus.readdata = mem_word(pending.pop_front());
    end
    bus.readdatavalid = rdv;
    #1;
    idle0    = !job_active;
    m_out0   = m_out;
    exp_done = zero_pend || (job_active && eb_addr.size() == 0 && m_out == 0);
    check("done", done, exp_done);
    check("busy", busy, job_active);
    check("out_valid", bus.out_valid, m_fifo > 0);
    if (!job_active) check("read_idle", bus.read, 0);
    if (prev_stall) begin
      check("hold_read", bus.read, 1);
      check("hold_addr", bus.address, prev_addr);
      check("hold_bc", bus.burstcount, prev_bc);
    end
    prev_stall = bus.read && bus.waitrequest;
    prev_addr  = bus.address;
    prev_bc    = bus.burstcount;
    if (bus.read) read_cnt++;
    if (prev_stall) stall_cnt++;
    acc = bus.read && !bus.waitrequest;
    if (acc) begin
      acc_cnt++;
      if (eb_addr.size() == 0) begin
        check("extra_burst", 1, 0);
      end else begin
        a = eb_addr.pop_front();
        l = eb_len.pop_front();
        check("burst_addr", bus.address, a);
        check("burst_len", bus.burstcount, l);
        check("credit", (m_fifo + m_out + l) <= int'(FIFO_DEPTH), 1);
        for (int k = 0; k < l; k++) pending.push_back(a + ADDR_W'(k));
        m_out += l;
      end
    end
    if (rdv && m_out0 > 0) begin
      m_fifo++;
      m_out--;
      m_chk ^= bus.readdata;
    end
    pop = bus.out_valid && bus.out_ready;
    if (pop) begin
      if (exp_data.size() == 0) check("extra_word", 1, 0);
      else check("out_data", bus.out_data, exp_data.pop_front());
      m_fifo--;
    end
    if (exp_done) begin
      done_cnt++;
      if (job_active) begin
`ifdef SDRAM_RD_CHECKSUM_EN
        check("checksum", checksum, m_chk);
`else
        check("checksum", checksum, 0);
`endif
      end
      job_active = 1'b0;
      zero_pend  = 1'b0;
    end
    if (start && idle0) accept_job(base_addr, int'(num_words));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.waitrequest = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", bus.read, 0);
    check("rst_addr", bus.address, 0);
    check("rst_bc", bus.burstcount, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_cksum", checksum, 0);
    eb_addr.delete();
    eb_len.delete();
    exp_data.delete();
    m_fifo = 0;
    m_out = 0;
    job_active = 1'b0;
    zero_pend = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] base, input int n);
    start_req = 1'b1;
    req_base  = base;
    req_n     = LEN_W'(n);
    step();
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int i = 0;
    while ((job_active || zero_pend || start_req || exp_data.size() != 0) && i < limit) begin
      step();
      i++;
    end
    if (i >= limit) check({tag, "_timeout"}, 0, 1);
  endtask

  int d0, r0, s0;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    bus.waitrequest = 1'b0; bus.readdata = '0; bus.readdatavalid = 1'b0; bus.out_ready = 1'b0;
    m_fifo = 0; m_out = 0; job_active = 0; zero_pend = 0; m_chk = '0;
    acc_cnt = 0; stall_cnt = 0; read_cnt = 0; done_cnt = 0; prev_stall = 0;
    prev_addr = '0; prev_bc = '0;
    ready_mode = 1; wr_hold = 0; wr_rand = 0; rsp_en = 1; rsp_rand = 0; noise_start = 0;
    mem_mode = 0; mem_base = '0; start_req = 0; req_base = '0; req_n = '0;
    do_reset();

    // Plain 40-word job: three bursts, one done.
    d0 = done_cnt;
    run_job(ADDR_W'(32'h100), 40);
    wait_idle(400, "t1");
    check("t1_bursts", acc_cnt, 3);
    check("t1_dones", done_cnt - d0, 1);

    // Five cycles of waitrequest on the first burst.
    s0 = stall_cnt;
    wr_hold = 5;
    run_job(ADDR_W'(32'h300), 20);
    wait_idle(400, "t2");
    check("t2_stalls", stall_cnt - s0, 5);
    check("t2_bursts", acc_cnt, 2);

    // Backpressure: credit limits issue to a full FIFO.
    d0 = done_cnt;
    ready_mode = 0;
    run_job(ADDR_W'(32'h1000), 200);
    repeat (60) step();
    check("t3_bursts_blocked", acc_cnt, 4);
    check("t3_read_low", bus.read, 0);
    check("t3_valid_high", bus.out_valid, 1);
    ready_mode = 1;
    wait_idle(2000, "t3");
    check("t3_bursts", acc_cnt, 13);
    check("t3_dones", done_cnt - d0, 1);

    // Zero-length job.
    d0 = done_cnt;
    r0 = read_cnt;
    run_job(ADDR_W'(32'h50), 0);
    step();
    step();
    check("t4_dones", done_cnt - d0, 1);
    check("t4_reads", read_cnt - r0, 0);

    // Reset with two bursts outstanding; stale beats must be dropped.
    ready_mode = 0;
    rsp_en = 0;
    run_job(ADDR_W'(32'h2000), 64);
    for (int i = 0; i < 50 && acc_cnt < 2; i++) step();
    check("t5_two_bursts", acc_cnt, 2);
    do_reset();
    rsp_en = 1;
    ready_mode = 1;
    repeat (40) step();
    check("t5_stale_dropped", bus.out_valid, 0);
    d0 = done_cnt;
    run_job(ADDR_W'(32'h40), 10);
    wait_idle(400, "t5");
    check("t5_dones", done_cnt - d0, 1);

    // Words 1..8: XOR is 8.
    mem_mode = 1;
    mem_base = ADDR_W'(32'h200);
    run_job(ADDR_W'(32'h200), 8);
    wait_idle(400, "t6");
`ifdef SDRAM_RD_CHECKSUM_EN
    check("t6_cksum", checksum, 8);
`else
    check("t6_cksum", checksum, 0);
`endif
    mem_mode = 0;

    // Random jobs under random waitrequest, backpressure, return gaps and stray starts.
    wr_rand = 1;
    ready_mode = 2;
    rsp_rand = 1;
    noise_start = 1;
    d0 = done_cnt;
    for (int j = 0; j < 10; j++) begin
      logic [ADDR_W-1:0] b;
      b = (j == 0) ? ADDR_W'({ADDR_W{1'b1}}) - ADDR_W'(5) : ADDR_W'($urandom);
      run_job(b, $urandom_range(1, 90));
      wait_idle(4000, "t7");
    end
    check("t7_dones", done_cnt - d0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_burst_reader.md
Name: sdram_burst_reader

Overview:
Parametrised Avalon-MM burst read master for the HPS F2H SDRAM port. It is the successor to the fixed read_sdram test block. On a start command it reads num_words consecutive words from SDRAM, splitting the job into bursts of up to MAX_BURST words. Returned data is buffered in an internal show-ahead FIFO and presented on a valid/ready stream. Credit-based issue means the FIFO can never overflow, whatever the downstream backpressure.

Parameters:
ADDR_W, 29, Avalon word-address width
DATA_W, 64, data word width
BURST_W, 8, burstcount width
MAX_BURST, 16, maximum words per burst; must be at most 2^(BURST_W-1) and at most FIFO_DEPTH
FIFO_DEPTH, 64, buffer depth in words; power of two
LEN_W, 24, width of the job length field

Ports:
clk  in  1  single clock for the block and the F2H SDRAM port
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle job request; sampled only in IDLE
base_addr  in  ADDR_W  word address of the first word
num_words  in  LEN_W  number of words to read
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the last word has entered the FIFO
address  out  ADDR_W  Avalon address
burstcount  out  BURST_W  Avalon burstcount
read  out  1  Avalon read
waitrequest  in  1  Avalon waitrequest
readdata  in  DATA_W  Avalon readdata
readdatavalid  in  1  Avalon readdatavalid
out_data  out  DATA_W  stream data (FIFO head)
out_valid  out  1  FIFO not empty
out_ready  in  1  stream consumer ready; a pop occurs when out_valid and out_ready are both high
checksum  out  DATA_W  job checksum (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, read=0, address=0, burstcount=0, out_valid=0, checksum=0. Reset also empties the FIFO and clears all counters. Reset has priority over every other event.
- State IDLE:
  - start with num_words>0: latch base_addr and num_words, set busy=1, go to ISSUE.
  - start with num_words=0: done=1 on the next cycle, busy stays 0, no read is issued.
- State ISSUE:
  - len = min(MAX_BURST, remaining).
  - Assert read with address=cur_addr and burstcount=len only when fifo_count + outstanding + len <= FIFO_DEPTH.
  - While read=1 and waitrequest=1, read, address and burstcount hold stable.
  - Acceptance is read & ~waitrequest. On acceptance: cur_addr += len, remaining -= len, outstanding += len.
  - read drops for at least 0 cycles: back-to-back bursts are allowed if credit permits.
  - When remaining reaches 0, go to DRAIN.
- State DRAIN: wait until outstanding=0, then pulse done=1 for one cycle, set busy=0, return to IDLE.
- Data return: each readdatavalid pushes readdata into the FIFO and decrements outstanding. On a cycle with both a burst acceptance and a returned word, outstanding = outstanding + len - 1.
- readdatavalid arriving while outstanding=0 (e.g. after a mid-job reset) is discarded and never pushed.
- FIFO: show-ahead; out_data is valid in the same cycle out_valid=1. Push and pop in the same cycle keep the count unchanged. Words leave in address order. FIFO contents may remain after done; the next job may start while data is still draining.
- start while busy=1 is ignored.
- Address arithmetic wraps modulo 2^ADDR_W. The remaining counter never underflows.
- Latency: read asserts 1 cycle after start is accepted. done asserts 1 cycle after the final readdatavalid.

Optional Feature:
- Macro: SDRAM_RD_CHECKSUM_EN.
- With the macro defined:
  - checksum is cleared to 0 on start acceptance.
  - Every word pushed into the FIFO is XOR-accumulated into checksum.
  - checksum is stable from the done pulse until the next start.
- Without the macro: the checksum port remains but is tied to 0, and no accumulator logic is built.

Test Plan:
- base_addr=0x100, num_words=40, MAX_BURST=16, waitrequest=0, out_ready=1 -> bursts (0x100,16), (0x110,16), (0x120,8); 40 words out in order; a single done pulse.
- waitrequest held high for 5 cycles on the first burst -> read, address=0x100 and burstcount=16 stable for all 5 cycles; exactly one acceptance.
- out_ready=0, FIFO_DEPTH=64, num_words=200 -> exactly 4 bursts of 16 issued, then read stays 0 and out_valid=1. Raise out_ready -> issue resumes; 200 words total, no overflow, done once.
- num_words=0 with start -> done=1 on the next cycle; read never asserted; busy stays 0.
- rst asserted mid-job with 2 bursts outstanding -> all outputs at reset values the next cycle. Late readdatavalid beats are discarded, out_valid stays 0, and a new job then completes correctly.
- SDRAM_RD_CHECKSUM_EN defined, memory words 1..8, num_words=8 -> checksum=8 at done. Macro undefined -> checksum=0.
